ifu_fetch: RTL and testbench

//   Instruction-fetch front end. Consumes the PC stream from the PC register and issues in-order

---
 rtl/ifu_fetch.sv | 127 ++++++++++++
 tb/tb_ifu_fetch.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: credit-limited in-order requests to the instruction bus,
// a small {addr,data} FIFO toward decode, and flush handling that drops stale responses.
module ifu_fetch #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              jump_flag_i,
   input  logic              hold_i,
   output logic              fetch_stall_o,
   output logic              ibus_req_o,
   output logic [ADDR_W-1:0] ibus_addr_o,
   input  logic              ibus_gnt_i,
   input  logic              ibus_rvalid_i,
   input  logic [DATA_W-1:0] ibus_rdata_i,
   output logic              inst_valid_o,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   input  logic              inst_ready_i
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   logic [ADDR_W-1:0] aq_mem   [DEPTH];
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [PW-1:0] aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] pending_q, pending_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] count_q, count_d;

   logic credit, grant, push, pop;

   // Credit uses registered counts only, so a pop frees a slot one cycle later.
   assign credit = ({1'b0, pending_q} + {1'b0, count_q}) < (CW + 1)'(DEPTH);

   assign ibus_req_o    = rst & credit & ~hold_i & ~jump_flag_i;
   assign ibus_addr_o   = pc_i;
   assign grant         = ibus_req_o & ibus_gnt_i;
   assign fetch_stall_o = ~grant;

   // Responses during a flush, or while stale responses remain, never reach the FIFO.
   assign push = ibus_rvalid_i & (discard_q == '0) & ~jump_flag_i;
   assign pop  = (count_q != '0) & inst_ready_i & ~jump_flag_i;

   assign inst_valid_o = (count_q != '0);
   assign inst_o       = inst_valid_o ? data_mem[rd_q] : NOP;
   assign inst_addr_o  = inst_valid_o ? addr_mem[rd_q] : '0;

   always_comb begin
      aq_wr_d   = aq_wr_q;
      aq_rd_d   = aq_rd_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      count_d   = count_q;
      discard_d = discard_q;
      pending_d = pending_q + CW'(grant) - CW'(ibus_rvalid_i);

      if (grant)
         aq_wr_d = ptr_inc(aq_wr_q);
      if (ibus_rvalid_i)
         aq_rd_d = ptr_inc(aq_rd_q);

      if (jump_flag_i) begin
         // Everything still outstanding after this cycle's response is stale.
         discard_d = pending_q - CW'(ibus_rvalid_i);
         wr_d      = '0;
         rd_d      = '0;
         count_d   = '0;
      end else begin
         if (ibus_rvalid_i && (discard_q != '0))
            discard_d = discard_q - CW'(1);
         if (push)
            wr_d = ptr_inc(wr_q);
         if (pop)
            rd_d = ptr_inc(rd_q);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aq_wr_q   <= '0;
         aq_rd_q   <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         count_q   <= '0;
         pending_q <= '0;
         discard_q <= '0;
      end else begin
         aq_wr_q   <= aq_wr_d;
         aq_rd_q   <= aq_rd_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         discard_q <= discard_d;
      end
   end

   // Storage needs no reset: contents are only observed through valid counts.
   always_ff @(posedge clk) begin
      if (grant)
         aq_mem[aq_wr_q] <= pc_i;
      if (push) begin
         addr_mem[wr_q] <= aq_mem[aq_rd_q];
         data_mem[wr_q] <= ibus_rdata_i;
      end
   end

   a_rvalid_pending: assert property (@(posedge clk) disable iff (!rst)
      !(ibus_rvalid_i && (pending_q == '0)));
   a_push_full: assert property (@(posedge clk) disable iff (!rst)
      !(push && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch (DEPTH=2): streaming, backpressure, flushes, bus wait, hold, reset.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_i = '0;
   logic        jump_flag_i = 1'b0;
   logic        hold_i = 1'b0;
   logic        fetch_stall_o;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i = 1'b0;
   logic        ibus_rvalid_i = 1'b0;
   logic [31:0] ibus_rdata_i = '0;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_ready_i = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   ifu_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .jump_flag_i(jump_flag_i), .hold_i(hold_i),
      .fetch_stall_o(fetch_stall_o), .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
      .ibus_gnt_i(ibus_gnt_i), .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
      .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
      .inst_ready_i(inst_ready_i)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] dat(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply one cycle's inputs; response data is derived from the address it answers.
   task automatic drive(input logic [31:0] pc, input logic jmp, input logic hld, input logic gt,
                        input logic rv, input logic [31:0] rv_addr, input logic rdy);
      pc_i = pc; jump_flag_i = jmp; hold_i = hld; ibus_gnt_i = gt;
      ibus_rvalid_i = rv; ibus_rdata_i = rv ? dat(rv_addr) : 32'h0; inst_ready_i = rdy;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic exp_bus(input string tag, input logic req, input logic stall, input logic [31:0] a);
      chk({tag, ".req"}, 32'(ibus_req_o), 32'(req));
      chk({tag, ".stall"}, 32'(fetch_stall_o), 32'(stall));
      if (req) chk({tag, ".addr"}, ibus_addr_o, a);
   endtask

   task automatic exp_inst(input string tag, input logic v, input logic [31:0] a);
      chk({tag, ".valid"}, 32'(inst_valid_o), 32'(v));
      if (v) begin
         chk({tag, ".iaddr"}, inst_addr_o, a);
         chk({tag, ".inst"}, inst_o, dat(a));
      end
      $display("step %s: valid=%0b inst_addr=%h inst=%h req=%0b stall=%0b",
               tag, inst_valid_o, inst_addr_o, inst_o, ibus_req_o, fetch_stall_o);
   endtask

   initial begin
      // Reset: outputs forced idle even with a grant offered
      drive(32'h0, 0, 0, 1, 0, 0, 1);
      exp_bus("rst", 0, 1, 0);
      chk("rst.valid", 32'(inst_valid_o), 32'h0);
      chk("rst.inst", inst_o, 32'h0000_0013);
      chk("rst.iaddr", inst_addr_o, 32'h0);
      tick; tick;
      rst = 1'b1;

      // 1 Stream
      drive(32'h0, 0, 0, 1, 0, 0, 1);      exp_bus("s0", 1, 0, 32'h0); exp_inst("s0", 0, 0); tick;
      drive(32'h4, 0, 0, 1, 1, 32'h0, 1);  exp_bus("s1", 1, 0, 32'h4); exp_inst("s1", 0, 0); tick;
      drive(32'h8, 0, 0, 1, 1, 32'h4, 1);  exp_bus("s2", 0, 1, 0);     exp_inst("s2", 1, 32'h0); tick;
      drive(32'h8, 0, 0, 1, 0, 0, 1);      exp_bus("s3", 1, 0, 32'h8); exp_inst("s3", 1, 32'h4); tick;
      drive(32'hC, 0, 0, 1, 1, 32'h8, 1);  exp_bus("s4", 1, 0, 32'hC); exp_inst("s4", 0, 0); tick;
      drive(32'hC, 0, 0, 0, 1, 32'hC, 1);  exp_bus("s5", 0, 1, 0);     exp_inst("s5", 1, 32'h8); tick;
      drive(32'h10, 0, 0, 0, 0, 0, 1);     exp_bus("s6", 1, 1, 32'h10); exp_inst("s6", 1, 32'hC); tick;

      // 2 Backpressure
      drive(32'h0, 0, 0, 1, 0, 0, 0);      exp_bus("b0", 1, 0, 32'h0); exp_inst("b0", 0, 0); tick;
      drive(32'h4, 0, 0, 1, 1, 32'h0, 0);  exp_bus("b1", 1, 0, 32'h4); exp_inst("b1", 0, 0); tick;
      drive(32'h8, 0, 0, 1, 1, 32'h4, 0);  exp_bus("b2", 0, 1, 0);     exp_inst("b2", 1, 32'h0); tick;
      drive(32'h8, 0, 0, 1, 0, 0, 0);      exp_bus("b3", 0, 1, 0);     exp_inst("b3", 1, 32'h0); tick;
      drive(32'h8, 0, 0, 1, 0, 0, 0);      exp_bus("b4", 0, 1, 0);     exp_inst("b4", 1, 32'h0); tick;
      drive(32'h8, 0, 0, 1, 0, 0, 0);      exp_bus("b5", 0, 1, 0);     exp_inst("b5", 1, 32'h0); tick;
      drive(32'h8, 0, 0, 1, 0, 0, 1);      exp_bus("b6", 0, 1, 0);     exp_inst("b6", 1, 32'h0); tick;
      drive(32'h8, 0, 0, 1, 0, 0, 1);      exp_bus("b7", 1, 0, 32'h8); exp_inst("b7", 1, 32'h4); tick;
      drive(32'hC, 0, 0, 0, 1, 32'h8, 1);  exp_bus("b8", 1, 1, 32'hC); exp_inst("b8", 0, 0); tick;
      drive(32'hC, 0, 0, 0, 0, 0, 1);      exp_inst("b9", 1, 32'h8); tick;

      // 3 Flush with a request in flight
      drive(32'h10, 0, 0, 1, 0, 0, 1);     exp_bus("f0", 1, 0, 32'h10); exp_inst("f0", 0, 0); tick;
      drive(32'h80, 1, 0, 1, 0, 0, 1);     exp_bus("f1", 0, 1, 0);      exp_inst("f1", 0, 0); tick;
      drive(32'h80, 0, 0, 1, 1, 32'h10, 1); exp_bus("f2", 1, 0, 32'h80); exp_inst("f2", 0, 0); tick;
      drive(32'h84, 0, 0, 0, 1, 32'h80, 1); exp_bus("f3", 1, 1, 32'h84); exp_inst("f3", 0, 0); tick;
      drive(32'h84, 0, 0, 0, 0, 0, 1);     exp_inst("f4", 1, 32'h80); tick;

      // 4 Flush coinciding with a response
      drive(32'h40, 0, 0, 1, 0, 0, 1);     exp_bus("g0", 1, 0, 32'h40); exp_inst("g0", 0, 0); tick;
      drive(32'h90, 1, 0, 1, 1, 32'h40, 1); exp_bus("g1", 0, 1, 0);     exp_inst("g1", 0, 0); tick;
      drive(32'h90, 0, 0, 1, 0, 0, 1);     exp_bus("g2", 1, 0, 32'h90); exp_inst("g2", 0, 0); tick;
      drive(32'h94, 0, 0, 0, 1, 32'h90, 1); exp_bus("g3", 1, 1, 32'h94); exp_inst("g3", 0, 0); tick;
      drive(32'h94, 0, 0, 0, 0, 0, 1);     exp_inst("g4", 1, 32'h90); tick;

      // Hold suppresses requests
      drive(32'h30, 0, 1, 1, 0, 0, 1);     exp_bus("h0", 0, 1, 0); exp_inst("h0", 0, 0); tick;

      // 5 Bus wait
      drive(32'h20, 0, 0, 0, 0, 0, 1);     exp_bus("w0", 1, 1, 32'h20); tick;
      drive(32'h20, 0, 0, 0, 0, 0, 1);     exp_bus("w1", 1, 1, 32'h20); tick;
      drive(32'h20, 0, 0, 0, 0, 0, 1);     exp_bus("w2", 1, 1, 32'h20); tick;
      drive(32'h20, 0, 0, 1, 0, 0, 1);     exp_bus("w3", 1, 0, 32'h20); exp_inst("w3", 0, 0); tick;
      drive(32'h24, 0, 0, 0, 1, 32'h20, 0); exp_bus("w4", 1, 1, 32'h24); exp_inst("w4", 0, 0); tick;
      drive(32'h24, 0, 0, 1, 0, 0, 0);     exp_bus("w5", 1, 0, 32'h24); exp_inst("w5", 1, 32'h20); tick;
      drive(32'h28, 0, 0, 1, 1, 32'h24, 0); exp_bus("w6", 0, 1, 0);     exp_inst("w6", 1, 32'h20); tick;
      drive(32'h28, 0, 0, 0, 0, 0, 0);     exp_bus("w7", 0, 1, 0);      exp_inst("w7", 1, 32'h20);

      // 6 Asynchronous reset with two words buffered
      rst = 1'b0;
      #1;
      chk("r.valid", 32'(inst_valid_o), 32'h0);
      chk("r.inst", inst_o, 32'h0000_0013);
      chk("r.iaddr", inst_addr_o, 32'h0);
      exp_bus("r", 0, 1, 0);
      tick;
      rst = 1'b1;
      drive(32'h0, 0, 0, 0, 0, 0, 1);      exp_bus("r1", 1, 1, 32'h0); exp_inst("r1", 0, 0); tick;
      exp_inst("r2", 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
